// File: rtl/mario_gfx_pkg.sv
// Shared graphics types and constants for the sprite pixel pipes.
package mario_gfx_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int          SCREEN_W        = 640;
    localparam int          SCREEN_H        = 480;
    localparam logic [23:0] KEY_RGB_DEFAULT = 24'hFF00FF;

endpackage

// File: rtl/sprite_bbox.sv
// Combinational sprite hit test: screen pixel vs. sprite box, yielding the ROM address.
module sprite_bbox
    import mario_gfx_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16
) (
    input  coord_t draw_x,
    input  coord_t draw_y,
    input  coord_t pos_x,
    input  coord_t pos_y,
    input  logic   face,
    output logic   in_box,
    output coord_t sprite_x,
    output coord_t sprite_y
);
    localparam logic [10:0] W = 11'(SPRITE_W);
    localparam logic [10:0] H = 11'(SPRITE_H);

    logic [10:0] dx, dy, sx_full, sy_full;

    // 11-bit difference: a pixel left of/above the box wraps to a huge value and fails the test
    always_comb begin
        dx       = {1'b0, draw_x} - {1'b0, pos_x};
        dy       = {1'b0, draw_y} - {1'b0, pos_y};
        in_box   = (dx < W) && (dy < H);
        sx_full  = face ? dx : (W - 11'd1 - dx);
        sy_full  = H - 11'd1 - dy;
        sprite_x = '0;
        sprite_y = '0;
        if (in_box) begin
            sprite_x = sx_full[9:0];
            sprite_y = sy_full[9:0];
        end
    end

endmodule

// File: rtl/mario_pixel_pipe.sv
// Two-stage Mario sprite compositor between the VGA controller and the sprite ROM,
// with a per-frame position latch so the sprite cannot tear.
module mario_pixel_pipe
    import mario_gfx_pkg::*;
#(
    parameter int          SPRITE_W = 16,
    parameter int          SPRITE_H = 16,
    parameter logic [23:0] KEY_RGB  = KEY_RGB_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pixel_en,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       HS_in,
    input  logic       VS_in,
    input  logic       BLANK_N_in,
    input  logic [7:0] BgR,
    input  logic [7:0] BgG,
    input  logic [7:0] BgB,
    input  logic [9:0] MarioX,
    input  logic [9:0] MarioY,
    input  logic       FaceLeft,
    output logic [9:0] SpriteX,
    output logic [9:0] SpriteY,
    input  logic [7:0] SpriteR,
    input  logic [7:0] SpriteG,
    input  logic [7:0] SpriteB,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       HS,
    output logic       VS,
    output logic       BLANK_N,
    output logic       mario_on
);
    coord_t pos_x, pos_y;
    logic   face, vs_prev;

    logic   box_c;
    coord_t sx_c, sy_c;

    logic   in_box1, hs1, vs1, blank1;
    rgb_t   bg1, pix, rom_rgb;
    logic   opaque;

    sprite_bbox #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_bbox (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .face     (face),
        .in_box   (box_c),
        .sprite_x (sx_c),
        .sprite_y (sy_c)
    );

    // ROM data arrives combinationally from the registered stage-1 address
    assign rom_rgb = {SpriteR, SpriteG, SpriteB};
    assign opaque  = in_box1 && (rom_rgb != KEY_RGB);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pos_x    <= '0;
            pos_y    <= '0;
            face     <= 1'b0;
            vs_prev  <= 1'b1;
            SpriteX  <= '0;
            SpriteY  <= '0;
            in_box1  <= 1'b0;
            bg1      <= '0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            blank1   <= 1'b0;
            pix      <= '0;
            mario_on <= 1'b0;
            HS       <= 1'b1;
            VS       <= 1'b1;
            BLANK_N  <= 1'b0;
        end else if (pixel_en) begin
            // New position takes effect from the tick after VS falls
            vs_prev <= VS_in;
            if (vs_prev && !VS_in) begin
                pos_x <= MarioX;
                pos_y <= MarioY;
                face  <= FaceLeft;
            end

            SpriteX <= sx_c;
            SpriteY <= sy_c;
            in_box1 <= box_c;
            bg1     <= {BgR, BgG, BgB};
            hs1     <= HS_in;
            vs1     <= VS_in;
            blank1  <= BLANK_N_in;

            HS      <= hs1;
            VS      <= vs1;
            BLANK_N <= blank1;
            if (!blank1) begin
                pix      <= '0;
                mario_on <= 1'b0;
            end else if (opaque) begin
                pix      <= rom_rgb;
                mario_on <= 1'b1;
            end else begin
                pix      <= bg1;
                mario_on <= 1'b0;
            end
        end
    end

    assign Red   = pix.r;
    assign Green = pix.g;
    assign Blue  = pix.b;

endmodule
